ped_req_conditioner: RTL

- Upstream stage of the traffic-light controller FSM.
- Turns the raw, bouncy pedestrian push-button into a clean, latched `ped_req` level that the FSM consumes.
- Holds `ped_req` until the FSM acknowledges service, then enforces a cooldown so one walk phase cannot be re-requested immediately.
- Drives a "WAIT" lamp for the pedestrian.

---
 rtl/ped_req_conditioner_if.sv | 15 +
 rtl/ped_req_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ped_req_conditioner_if.sv
// Pedestrian request bundle between the button conditioner and the TLC FSM side.
// master drives the raw button and the grant; slave is the conditioner.
interface ped_req_conditioner_if;
  logic       btn_raw;
  logic       ped_ack;
  logic       ped_req;
  logic       wait_lamp;
  logic       ped_urgent;
  logic [1:0] state_dbg;

  modport master (output btn_raw, ped_ack,
                  input  ped_req, wait_lamp, ped_urgent, state_dbg);
  modport slave  (input  btn_raw, ped_ack,
                  output ped_req, wait_lamp, ped_urgent, state_dbg);
endinterface

// File: rtl/ped_req_conditioner.sv
// Pedestrian button conditioner: sync, debounce, latched request, post-grant cooldown.
// Define PED_URGENT_EN to build the PENDING wait timer that drives ped_urgent.
module ped_req_conditioner #(
  parameter int DEB_CYCLES      = 4,
  parameter int COOLDOWN_CYCLES = 20,
  parameter int MAX_WAIT_CYCLES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  ped_req_conditioner_if.slave  bus
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_CYCLES - 1);

  if (DEB_CYCLES < 1 || COOLDOWN_CYCLES < 1 || MAX_WAIT_CYCLES < 1) begin : g_bad_param
    $error("ped_req_conditioner: all cycle parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PENDING  = 2'b01,
    COOLDOWN = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  logic          sync1, btn_s, btn_d, btn_d_q;
  logic [DW-1:0] deb_cnt;
  logic          press;

  // Counter only ever reaches DEB_LAST before clearing, so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      btn_d   <= 1'b0;
      btn_d_q <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1   <= bus.btn_raw;
      btn_s   <= sync1;
      btn_d_q <= btn_d;
      if (btn_s == btn_d) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_d   <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press = btn_d & ~btn_d_q;

  state_t        state, state_n;
  logic          req_r, req_n;
  logic          lamp_r, lamp_n;
  logic          queued, queued_n;
  logic [CW-1:0] cd_cnt, cd_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req_r  <= 1'b0;
      lamp_r <= 1'b0;
      queued <= 1'b0;
      cd_cnt <= '0;
    end else begin
      state  <= state_n;
      req_r  <= req_n;
      lamp_r <= lamp_n;
      queued <= queued_n;
      cd_cnt <= cd_n;
    end
  end

  always_comb begin
    state_n  = state;
    req_n    = req_r;
    lamp_n   = lamp_r;
    queued_n = queued;
    cd_n     = cd_cnt;
    case (state)
      IDLE: begin
        if (press) begin
          state_n = PENDING;
          req_n   = 1'b1;
          lamp_n  = 1'b1;
        end
      end
      PENDING: begin
        // A press coinciding with the grant is part of this walk, not a new one.
        if (bus.ped_ack) begin
          state_n = COOLDOWN;
          req_n   = 1'b0;
          lamp_n  = 1'b0;
          cd_n    = CD_LOAD;
        end
      end
      COOLDOWN: begin
        if (cd_cnt == '0) begin
          queued_n = 1'b0;
          if (queued || press) begin
            state_n = PENDING;
            req_n   = 1'b1;
            lamp_n  = 1'b1;
          end else begin
            state_n = IDLE;
            req_n   = 1'b0;
            lamp_n  = 1'b0;
          end
        end else begin
          cd_n = cd_cnt - 1'b1;
          if (press) begin
            queued_n = 1'b1;
            lamp_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        req_n    = 1'b0;
        lamp_n   = 1'b0;
        queued_n = 1'b0;
        cd_n     = '0;
      end
    endcase
  end

`ifdef PED_URGENT_EN
  localparam int WW = $clog2(MAX_WAIT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT_CYCLES);

  logic [WW-1:0] wait_cnt, wait_n;
  logic          urg_r, urg_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      urg_r    <= 1'b0;
    end else begin
      wait_cnt <= wait_n;
      urg_r    <= urg_n;
    end
  end

  // Timer lives only inside PENDING; every entry starts it from zero.
  always_comb begin
    wait_n = '0;
    urg_n  = 1'b0;
    if (state == PENDING && !bus.ped_ack) begin
      wait_n = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      urg_n  = (wait_n == WAIT_MAX);
    end
  end

  assign bus.ped_urgent = urg_r;
`else
  assign bus.ped_urgent = 1'b0;
`endif

  assign bus.ped_req   = req_r;
  assign bus.wait_lamp = lamp_r;
  assign bus.state_dbg = state;
endmodule
